// File: rtl/apb_write_cmd_pkg.sv
// apb_cmd_pkg: shared constants for the RS485 command-path APB slave.
//   DEPTH/AW/DW : command buffer geometry (32 x 8)
//   CW          : width of the occupancy count (0..DEPTH inclusive)
//   ADDR_*      : register map
//   CTRL_*      : bit positions inside the CTRL register
//   state_e     : APB handshake FSM encoding
`timescale 1ns/1ps
package apb_cmd_pkg;
    localparam int DEPTH = 32;
    localparam int AW    = $clog2(DEPTH);
    localparam int DW    = 8;
    localparam int CW    = AW + 1;

    localparam logic [7:0] ADDR_DATA = 8'h00;
    localparam logic [7:0] ADDR_CTRL = 8'h04;
    localparam logic [7:0] ADDR_FREE = 8'h08;
    localparam logic [7:0] ADDR_STAT = 8'h0C;

    localparam int CTRL_FLUSH = 0;
    localparam int CTRL_START = 1;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_e;
endpackage

// File: rtl/apb_write_cmd_if.sv
// apb_write_cmd_if: APB bus bundle between the host and the command slave.
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA : requester -> slave
//   PREADY/PRDATA/PSLVERR            : slave -> requester
`timescale 1ns/1ps
interface apb_write_cmd_if;
    import apb_cmd_pkg::*;

    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [7:0]    PADDR;
    logic [15:0]   PWDATA;
    logic          PREADY;
    logic [DW-1:0] PRDATA;
    logic          PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/apb_write_cmd_ptr_ctrl.sv
// cmd_ptr_ctrl: write pointer and occupancy tracking for the command buffer.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   push_i        : one byte was written into the buffer this cycle
//   pop_i         : transmitter consumed one byte this cycle
//   flush_i       : discard everything (beats push and pop)
//   wptr_o        : next buffer write address, wraps at DEPTH
//   count_o       : bytes held, 0..DEPTH
//   full_o/empty_o: occupancy flags from the registered count
//   drain_o       : this cycle's pop takes the count from 1 to 0
`timescale 1ns/1ps
module cmd_ptr_ctrl
    import apb_cmd_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [AW-1:0] wptr_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          drain_o
);
    logic [AW-1:0] wptr_q, wptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop_ok;

    // A pop on an empty buffer is a transmitter glitch; drop it.
    assign pop_ok = pop_i && (count_q != '0);

    always_comb begin
        wptr_d  = wptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) wptr_d = wptr_q + 1'b1;
            // Push and pop on the same edge cancel out.
            unique case ({push_i, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    assign wptr_o  = wptr_q;
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign drain_o = pop_ok && !push_i && !flush_i && (count_q == CW'(1));
endmodule

// File: rtl/apb_write_cmd.sv
// apb_write_cmd: APB slave feeding the RS485 command (transmit) buffer.
//   PCLK, rst_tx          : clock, synchronous active-low reset
//   apb                   : APB slave port (one wait state, PREADY registered)
//   WCLK_CMD/W_ADDR_CMD/WD_CMD : external 32x8 buffer write port
//   TX_POP                : transmitter consumed one byte
//   TX_START              : one-cycle pulse to launch transmission
//   CMD_COUNT             : bytes currently buffered
`timescale 1ns/1ps
module apb_write_cmd
    import apb_cmd_pkg::*;
(
    input  logic                 PCLK,
    input  logic                 rst_tx,
    apb_write_cmd_if.slave       apb,
    output logic                 WCLK_CMD,
    output logic [AW-1:0]        W_ADDR_CMD,
    output logic [DW-1:0]        WD_CMD,
    input  logic                 TX_POP,
    output logic                 TX_START,
    output logic [CW-1:0]        CMD_COUNT
);
    state_e        state_q, state_d;
    logic          pready_q, pready_d;
    logic [DW-1:0] prdata_q, prdata_d;
    logic          pslverr_q, pslverr_d;
    logic          wclk_q, wclk_d;
    logic [DW-1:0] wd_q, wd_d;
    logic          start_q, start_d;
    logic          ovf_q, ovf_d;
    logic          busy_q, busy_d;
    logic          flush;

    logic [AW-1:0] wptr;
    logic [CW-1:0] count;
    logic          full, empty, drain;
    logic          unused_pwdata;

    assign unused_pwdata = ^apb.PWDATA[15:DW];

    // The buffer write strobe is only ever high in ACK, so it doubles as the
    // push that advances the pointer on the ACK->IDLE edge.
    cmd_ptr_ctrl u_ptr (
        .clk_i   (PCLK),
        .rst_ni  (rst_tx),
        .push_i  (wclk_q),
        .pop_i   (TX_POP),
        .flush_i (flush),
        .wptr_o  (wptr),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty),
        .drain_o (drain)
    );

    // Every side effect is decided in IDLE while the access phase is seen;
    // ACK only presents the registered response and returns.
    always_comb begin
        state_d   = state_q;
        pready_d  = 1'b0;
        prdata_d  = '0;
        pslverr_d = 1'b0;
        wclk_d    = 1'b0;
        wd_d      = wd_q;
        start_d   = 1'b0;
        ovf_d     = ovf_q;
        busy_d    = busy_q;
        flush     = 1'b0;

        if (drain) busy_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (apb.PSEL && apb.PENABLE) begin
                    state_d  = ACK;
                    pready_d = 1'b1;
                    if (apb.PWRITE) begin
                        unique case (apb.PADDR)
                            ADDR_DATA: begin
                                if (!full) begin
                                    wd_d   = apb.PWDATA[DW-1:0];
                                    wclk_d = 1'b1;
                                end else begin
                                    ovf_d     = 1'b1;
                                    pslverr_d = 1'b1;
                                end
                            end
                            ADDR_CTRL: begin
                                if (apb.PWDATA[CTRL_FLUSH]) begin
                                    flush  = 1'b1;
                                    ovf_d  = 1'b0;
                                    busy_d = 1'b0;
                                end else if (apb.PWDATA[CTRL_START] && !empty) begin
                                    start_d = 1'b1;
                                    busy_d  = 1'b1;
                                end
                            end
                            default: pslverr_d = 1'b1;
                        endcase
                    end else begin
                        unique case (apb.PADDR)
                            ADDR_FREE: prdata_d = {{(DW-CW){1'b0}}, CW'(DEPTH) - count};
                            ADDR_STAT: prdata_d = {4'b0, busy_q, ovf_q, full, empty};
                            default:   pslverr_d = 1'b1;
                        endcase
                    end
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!rst_tx) begin
            state_q   <= IDLE;
            pready_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            wclk_q    <= 1'b0;
            wd_q      <= '0;
            start_q   <= 1'b0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pready_q  <= pready_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
            wclk_q    <= wclk_d;
            wd_q      <= wd_d;
            start_q   <= start_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
        end
    end

    assign apb.PREADY  = pready_q;
    assign apb.PRDATA  = prdata_q;
    assign apb.PSLVERR = pslverr_q;
    assign WCLK_CMD    = wclk_q;
    assign W_ADDR_CMD  = wptr;
    assign WD_CMD      = wd_q;
    assign TX_START    = start_q;
    assign CMD_COUNT   = count;
endmodule

// File: tb/tb_apb_write_cmd.sv
`timescale 1ns/1ps
module tb_apb_write_cmd;
    import apb_cmd_pkg::*;

    logic       PCLK   = 1'b0;
    logic       rst_tx = 1'b0;
    logic       TX_POP = 1'b0;
    logic       WCLK_CMD, TX_START;
    logic [4:0] W_ADDR_CMD;
    logic [7:0] WD_CMD;
    logic [5:0] CMD_COUNT;

    apb_write_cmd_if bus ();

    apb_write_cmd dut (
        .PCLK       (PCLK),
        .rst_tx     (rst_tx),
        .apb        (bus),
        .WCLK_CMD   (WCLK_CMD),
        .W_ADDR_CMD (W_ADDR_CMD),
        .WD_CMD     (WD_CMD),
        .TX_POP     (TX_POP),
        .TX_START   (TX_START),
        .CMD_COUNT  (CMD_COUNT)
    );

    always #5 PCLK = ~PCLK;

    typedef struct packed {
        logic       err;
        logic [7:0] rdata;
        logic       wclk;
        logic [4:0] waddr;
        logic [7:0] wd;
        logic       txs;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // reference model state
    int         m_count = 0;
    int         m_wptr  = 0;
    bit         m_ovf   = 1'b0;
    bit         m_busy  = 1'b0;
    logic [7:0] m_wd    = 8'h00;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Expected ACK-cycle response of one access, and model update.
    task automatic predict(input bit wr, input logic [7:0] addr, input logic [15:0] data,
                           input bit pop_ack, output exp_t e);
        bit pushed;
        pushed  = 1'b0;
        e       = '0;
        e.waddr = m_wptr[4:0];
        e.wd    = m_wd;
        if (wr && addr == 8'h00) begin
            if (m_count < 32) begin
                pushed = 1'b1;
                e.wclk = 1'b1;
                m_wd   = data[7:0];
                e.wd   = m_wd;
            end else begin
                e.err = 1'b1;
                m_ovf = 1'b1;
            end
        end else if (wr && addr == 8'h04) begin
            if (data[0]) begin
                m_wptr = 0; m_count = 0; m_ovf = 1'b0; m_busy = 1'b0;
                e.waddr = 5'd0;
            end else if (data[1] && m_count != 0) begin
                e.txs  = 1'b1;
                m_busy = 1'b1;
            end
        end else if (!wr && addr == 8'h08) begin
            e.rdata = 8'(32 - m_count);
        end else if (!wr && addr == 8'h0C) begin
            e.rdata = {4'b0, m_busy, m_ovf, m_count == 32, m_count == 0};
        end else begin
            e.err = 1'b1;
        end
        if (pushed) m_wptr = (m_wptr + 1) % 32;
        if (pushed && !pop_ack) m_count++;
        else if (!pushed && pop_ack && m_count > 0) begin
            m_count--;
            if (m_count == 0) m_busy = 1'b0;
        end
    endtask

    task automatic xfer(input bit wr, input logic [7:0] addr, input logic [15:0] data,
                        input bit pop_ack, input string tag);
        exp_t e;
        int   n;
        predict(wr, addr, data, pop_ack, e);
        exp_q.push_back(e);
        @(posedge PCLK); #1;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr; bus.PADDR = addr; bus.PWDATA = data;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1;
        n = 0;
        @(negedge PCLK);
        while (bus.PREADY !== 1'b1 && n < 8) begin
            @(negedge PCLK);
            n++;
        end
        chk({tag, " wait"}, n, 1);
        e = exp_q.pop_front();
        chk({tag, " pslverr"}, bus.PSLVERR, e.err);
        chk({tag, " prdata"},  bus.PRDATA,  e.rdata);
        chk({tag, " wclk"},    WCLK_CMD,    e.wclk);
        chk({tag, " waddr"},   W_ADDR_CMD,  e.waddr);
        chk({tag, " wd"},      WD_CMD,      e.wd);
        chk({tag, " txstart"}, TX_START,    e.txs);
        if (pop_ack) TX_POP = 1'b1;
        @(posedge PCLK); #1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; TX_POP = 1'b0;
        @(negedge PCLK);
        chk({tag, " count"},      CMD_COUNT,  m_count);
        chk({tag, " pready_off"}, bus.PREADY, 0);
        chk({tag, " wclk_off"},   WCLK_CMD,   0);
        chk({tag, " txs_off"},    TX_START,   0);
    endtask

    task automatic tx_pop();
        @(posedge PCLK); #1;
        TX_POP = 1'b1;
        @(posedge PCLK); #1;
        TX_POP = 1'b0;
        if (m_count > 0) begin
            m_count--;
            if (m_count == 0) m_busy = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        bus.PADDR = 8'h00; bus.PWDATA = 16'h0000;
        rst_tx = 1'b0;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        chk("rst pready",  bus.PREADY,  0);
        chk("rst pslverr", bus.PSLVERR, 0);
        chk("rst prdata",  bus.PRDATA,  0);
        chk("rst wclk",    WCLK_CMD,    0);
        chk("rst waddr",   W_ADDR_CMD,  0);
        chk("rst wd",      WD_CMD,      0);
        chk("rst txstart", TX_START,    0);
        chk("rst count",   CMD_COUNT,   0);
        @(posedge PCLK); #1;
        rst_tx = 1'b1;

        // single write
        xfer(1'b1, 8'h00, 16'h00A5, 1'b0, "wr_a5");
        chk("wr_a5 count_lit", CMD_COUNT, 1);

        // fill past full
        xfer(1'b1, 8'h04, 16'h0001, 1'b0, "flush1");
        for (int i = 0; i < 33; i++)
            xfer(1'b1, 8'h00, 16'(16'hAB00 + i), 1'b0, $sformatf("fill%0d", i));
        chk("wrap waddr", W_ADDR_CMD, 0);
        chk("full count", CMD_COUNT, 32);
        xfer(1'b0, 8'h0C, 16'h0, 1'b0, "stat_full");
        xfer(1'b0, 8'h08, 16'h0, 1'b0, "free_full");

        // start, drain by pops
        xfer(1'b1, 8'h04, 16'h0001, 1'b0, "flush2");
        xfer(1'b1, 8'h04, 16'h0002, 1'b0, "start_empty");
        for (int i = 0; i < 3; i++)
            xfer(1'b1, 8'h00, 16'(16'h0030 + i), 1'b0, $sformatf("w3_%0d", i));
        xfer(1'b1, 8'h04, 16'h0002, 1'b0, "start");
        xfer(1'b0, 8'h0C, 16'h0, 1'b0, "stat_busy");
        for (int i = 0; i < 3; i++) tx_pop();
        @(negedge PCLK);
        chk("drain count", CMD_COUNT, 0);
        xfer(1'b0, 8'h0C, 16'h0, 1'b0, "stat_drained");
        xfer(1'b0, 8'h08, 16'h0, 1'b0, "free_empty");

        // push coincident with pop, pop on empty
        for (int i = 0; i < 5; i++)
            xfer(1'b1, 8'h00, 16'(16'h0050 + i), 1'b0, $sformatf("w5_%0d", i));
        xfer(1'b1, 8'h00, 16'h0077, 1'b1, "push_pop");
        chk("push_pop count_lit", CMD_COUNT, 5);
        xfer(1'b1, 8'h04, 16'h0001, 1'b0, "flush3");
        tx_pop();
        @(negedge PCLK);
        chk("pop_empty count", CMD_COUNT, 0);

        // flush beats start with OVF set
        for (int i = 0; i < 33; i++)
            xfer(1'b1, 8'h00, 16'(i), 1'b0, $sformatf("ovf%0d", i));
        for (int i = 0; i < 28; i++) tx_pop();
        @(negedge PCLK);
        chk("pre_flush count", CMD_COUNT, 4);
        xfer(1'b1, 8'h04, 16'h0003, 1'b0, "flush_start");
        chk("flush_start waddr", W_ADDR_CMD, 0);
        xfer(1'b0, 8'h0C, 16'h0, 1'b0, "stat_flushed");

        // illegal accesses
        xfer(1'b1, 8'h08, 16'h0011, 1'b0, "wr_free");
        xfer(1'b1, 8'h0C, 16'h0011, 1'b0, "wr_stat");
        xfer(1'b0, 8'h00, 16'h0, 1'b0, "rd_data");
        xfer(1'b0, 8'h04, 16'h0, 1'b0, "rd_ctrl");

        // reset during ACK of a data write
        @(posedge PCLK); #1;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
        bus.PADDR = 8'h00; bus.PWDATA = 16'h003C;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1;
        @(posedge PCLK); #1;
        chk("rst_ack pready", bus.PREADY, 1);
        chk("rst_ack wclk",   WCLK_CMD,   1);
        rst_tx = 1'b0;
        @(posedge PCLK); #1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        chk("rst_mid pready", bus.PREADY, 0);
        chk("rst_mid wclk",   WCLK_CMD,   0);
        chk("rst_mid count",  CMD_COUNT,  0);
        chk("rst_mid waddr",  W_ADDR_CMD, 0);
        @(posedge PCLK); #1;
        rst_tx = 1'b1;
        m_count = 0; m_wptr = 0; m_ovf = 1'b0; m_busy = 1'b0; m_wd = 8'h00;
        xfer(1'b0, 8'h20, 16'h0, 1'b0, "bad_addr");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
